// File: rtl/eeprom_rx_path.sv
// SPI EEPROM receive path: deserializes MISO into bytes, feeds the rx FIFO through a
// one-entry holding register, and tracks length/done/overflow. Define EEPROM_RX_CRC_EN for CRC-8.
module eeprom_rx_path #(
    parameter int LEN_W  = 12,
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              RX_START,
    input  logic [LEN_W-1:0]  RX_LEN,
    input  logic              RX_ABORT,
    input  logic              SCK_RISE,
    input  logic              MISO,
    input  logic              FIFO_FULL,
    output logic              FIFO_WE,
    output logic [DATA_W-1:0] FIFO_DATA,
    output logic              RX_BUSY,
    output logic              RX_DONE,
    output logic              RX_OVF,
    output logic [LEN_W-1:0]  BYTE_CNT,
    output logic [7:0]        RX_CRC
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DRAIN
    } state_t;

    state_t              state, state_next;
    logic                rst_sync;
    logic [DATA_W-1:0]   shreg;
    logic [2:0]          bit_cnt;
    logic [DATA_W-1:0]   hold_q;
    logic                hold_vld;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    byte_cnt_q;
    logic                fifo_we_q;
    logic [DATA_W-1:0]   fifo_data_q;
    logic                done_q;
    logic                done_next;
    logic                ovf_q;

    logic                start_ok;
    logic                start_load;
    logic                bit_strobe;
    logic                byte_done;
    logic                hold_drain;
    logic                direct_wr;
    logic                to_hold;
    logic                drop;
    logic [DATA_W-1:0]   new_byte;
    logic [LEN_W-1:0]    cnt_inc;

    // Reset assertion is immediate; release is retimed so logic first moves on the 2nd edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) rst_sync <= 1'b0;
        else        rst_sync <= 1'b1;
    end

    assign start_ok   = (state == IDLE) && RX_START && !RX_ABORT;
    assign start_load = start_ok && (RX_LEN != '0);
    assign bit_strobe = (state == SHIFT) && SCK_RISE && !RX_ABORT;
    assign byte_done  = bit_strobe && (bit_cnt == 3'd7);
    assign new_byte   = {shreg[DATA_W-2:0], MISO};
    assign cnt_inc    = byte_cnt_q + LEN_W'(1);

    // The held byte drains first; a byte completing alongside it takes the freed slot.
    assign hold_drain = hold_vld && !FIFO_FULL && !RX_ABORT;
    assign direct_wr  = byte_done && !hold_vld && !FIFO_FULL;
    assign to_hold    = byte_done && (hold_drain || (!hold_vld && FIFO_FULL));
    assign drop       = byte_done && hold_vld && !hold_drain;

    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) state <= IDLE;
        else           state <= state_next;
    end

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (RX_LEN != '0) state_next = SHIFT;
                    else              done_next  = 1'b1;
                end
            end
            SHIFT: begin
                if (RX_ABORT)                           state_next = IDLE;
                else if (byte_done && cnt_inc == len_q) state_next = DRAIN;
            end
            DRAIN: begin
                if (RX_ABORT) begin
                    state_next = IDLE;
                end else if (!hold_vld) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef EEPROM_RX_CRC_EN
    logic [7:0] crc_q;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        return c;
    endfunction

    // Dropped bytes are still folded in: the CRC covers what the EEPROM sent.
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync)      crc_q <= 8'h00;
        else if (start_load) crc_q <= 8'h00;
        else if (byte_done)  crc_q <= crc8_byte(crc_q, new_byte);
    end

    assign RX_CRC = crc_q;
`else
    assign RX_CRC = 8'h00;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge rst_sync) begin
        if (!rst_sync) begin
            shreg       <= '0;
            bit_cnt     <= 3'd0;
            hold_q      <= '0;
            hold_vld    <= 1'b0;
            len_q       <= '0;
            byte_cnt_q  <= '0;
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            fifo_we_q <= 1'b0;
            done_q    <= done_next;
            if (RX_ABORT) begin
                hold_vld <= 1'b0;
                bit_cnt  <= 3'd0;
                shreg    <= '0;
            end else if (start_load) begin
                len_q      <= RX_LEN;
                bit_cnt    <= 3'd0;
                shreg      <= '0;
                byte_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (bit_strobe) begin
                    shreg   <= new_byte;
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (hold_drain) begin
                    fifo_we_q   <= 1'b1;
                    fifo_data_q <= hold_q;
                    hold_vld    <= 1'b0;
                end else if (direct_wr) begin
                    fifo_we_q   <= 1'b1;
                    fifo_data_q <= new_byte;
                end
                if (to_hold) begin
                    hold_q   <= new_byte;
                    hold_vld <= 1'b1;
                end
                if (drop) ovf_q <= 1'b1;
                if (byte_done && byte_cnt_q != len_q) byte_cnt_q <= cnt_inc;
            end
        end
    end

    assign FIFO_WE   = fifo_we_q;
    assign FIFO_DATA = fifo_data_q;
    assign RX_BUSY   = (state != IDLE);
    assign RX_DONE   = done_q;
    assign RX_OVF    = ovf_q;
    assign BYTE_CNT  = byte_cnt_q;

endmodule

// File: tb/tb_eeprom_rx_path.sv
// Directed bench for eeprom_rx_path: single byte, backpressure/overflow, zero length,
// abort, async reset, and CRC-8 (expects 8'h00 unless EEPROM_RX_CRC_EN is defined).
module tb_eeprom_rx_path;

    localparam int LEN_W = 12;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             RX_START;
    logic [LEN_W-1:0] RX_LEN;
    logic             RX_ABORT;
    logic             SCK_RISE;
    logic             MISO;
    logic             FIFO_FULL;
    logic             FIFO_WE;
    logic [7:0]       FIFO_DATA;
    logic             RX_BUSY;
    logic             RX_DONE;
    logic             RX_OVF;
    logic [LEN_W-1:0] BYTE_CNT;
    logic [7:0]       RX_CRC;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [7:0] wr_log[$];

    eeprom_rx_path #(.LEN_W(LEN_W), .DATA_W(8)) dut (
        .CLK(CLK), .RESET(RESET), .RX_START(RX_START), .RX_LEN(RX_LEN),
        .RX_ABORT(RX_ABORT), .SCK_RISE(SCK_RISE), .MISO(MISO), .FIFO_FULL(FIFO_FULL),
        .FIFO_WE(FIFO_WE), .FIFO_DATA(FIFO_DATA), .RX_BUSY(RX_BUSY), .RX_DONE(RX_DONE),
        .RX_OVF(RX_OVF), .BYTE_CNT(BYTE_CNT), .RX_CRC(RX_CRC)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FIFO_WE) begin
            wr_cnt++;
            wr_log.push_back(FIFO_DATA);
        end
        if (RX_DONE) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic start(input logic [LEN_W-1:0] len);
        RX_LEN   = len;
        RX_START = 1'b1;
        tick();
        RX_START = 1'b0;
    endtask

    // Returns right after the edge that captures the last bit.
    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            SCK_RISE = 1'b1;
            MISO     = b[7-i];
            tick();
            SCK_RISE = 1'b0;
            if (i != n - 1) tick();
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (RX_DONE) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        int base_wr;
        int base_done;
        logic [7:0] crc_bytes[9];

        RESET = 1'b0; RX_START = 1'b0; RX_LEN = '0; RX_ABORT = 1'b0;
        SCK_RISE = 1'b0; MISO = 1'b0; FIFO_FULL = 1'b0;
        tick(3);
        check("rst_we",   FIFO_WE,   1'b0);
        check("rst_data", FIFO_DATA, 8'h00);
        check("rst_busy", RX_BUSY,   1'b0);
        check("rst_done", RX_DONE,   1'b0);
        check("rst_ovf",  RX_OVF,    1'b0);
        check("rst_cnt",  BYTE_CNT,  12'd0);
        check("rst_crc",  RX_CRC,    8'h00);
        RESET = 1'b1;
        tick(3);

        // Single byte A5
        start(12'd1);
        check("sb_busy0", RX_BUSY, 1'b1);
        send_bits(8'hA5, 8);
        check("sb_we",   FIFO_WE,   1'b1);
        check("sb_data", FIFO_DATA, 8'hA5);
        check("sb_cnt",  BYTE_CNT,  12'd1);
        tick();
        check("sb_done", RX_DONE, 1'b1);
        check("sb_busy", RX_BUSY, 1'b0);
        tick();
        check("sb_done_pulse", RX_DONE, 1'b0);

        // Backpressure: 11 written, 22 held, 33 dropped
        base_wr = wr_cnt;
        start(12'd3);
        send_bits(8'h11, 8);
        check("bp_we1",   FIFO_WE,   1'b1);
        check("bp_data1", FIFO_DATA, 8'h11);
        FIFO_FULL = 1'b1;
        tick();
        send_bits(8'h22, 8);
        check("bp_we2", FIFO_WE, 1'b0);
        check("bp_ovf2", RX_OVF, 1'b0);
        tick();
        send_bits(8'h33, 8);
        check("bp_we3",  FIFO_WE,  1'b0);
        check("bp_ovf",  RX_OVF,   1'b1);
        check("bp_cnt",  BYTE_CNT, 12'd3);
        base_done = done_cnt;
        tick(20);
        check("bp_no_done", done_cnt, base_done);
        check("bp_busy",    RX_BUSY,  1'b1);
        FIFO_FULL = 1'b0;
        tick();
        check("bp_we_late",   FIFO_WE,   1'b1);
        check("bp_data_late", FIFO_DATA, 8'h22);
        check("bp_done_early", RX_DONE,  1'b0);
        tick();
        check("bp_done", RX_DONE, 1'b1);
        check("bp_wr_total", wr_cnt - base_wr, 2);
        check("bp_log", wr_log[wr_log.size()-1], 8'h22);

        // Zero length
        tick(2);
        base_wr = wr_cnt;
        start(12'd0);
        check("zl_done", RX_DONE, 1'b1);
        check("zl_busy", RX_BUSY, 1'b0);
        tick();
        check("zl_done_pulse", RX_DONE, 1'b0);
        check("zl_no_we", wr_cnt, base_wr);

        // Abort mid-byte, then a clean byte 5A
        start(12'd4);
        check("ab_ovf_clr", RX_OVF, 1'b0);
        send_bits(8'hFF, 8);
        tick();
        send_bits(8'hFF, 5);
        base_done = done_cnt;
        RX_ABORT = 1'b1;
        tick();
        RX_ABORT = 1'b0;
        check("ab_busy", RX_BUSY,  1'b0);
        check("ab_cnt",  BYTE_CNT, 12'd1);
        tick(3);
        check("ab_no_done", done_cnt, base_done);
        start(12'd1);
        send_bits(8'h5A, 8);
        check("ab_we",   FIFO_WE,   1'b1);
        check("ab_data", FIFO_DATA, 8'h5A);
        wait_done("ab_done", 10);

        // Async reset with a valid holding byte
        tick(2);
        start(12'd2);
        FIFO_FULL = 1'b1;
        send_bits(8'hC3, 8);
        check("ar_held", FIFO_WE, 1'b0);
        tick();
        send_bits(8'hFF, 3);
        #2;
        RESET = 1'b0;
        #1;
        check("ar_busy", RX_BUSY,   1'b0);
        check("ar_cnt",  BYTE_CNT,  12'd0);
        check("ar_data", FIFO_DATA, 8'h00);
        check("ar_we",   FIFO_WE,   1'b0);
        check("ar_done", RX_DONE,   1'b0);
        FIFO_FULL = 1'b0;
        base_wr = wr_cnt;
        tick(2);
        RESET = 1'b1;
        tick(10);
        check("ar_no_we",   wr_cnt,  base_wr);
        check("ar_idle",    RX_BUSY, 1'b0);

        // CRC-8 over "123456789"
        for (int i = 0; i < 9; i++) crc_bytes[i] = 8'h31 + 8'(i);
        start(12'd9);
        for (int i = 0; i < 9; i++) begin
            send_bits(crc_bytes[i], 8);
            tick();
        end
        check("crc_cnt", BYTE_CNT, 12'd9);
        if (!RX_DONE) wait_done("crc_done", 10);
`ifdef EEPROM_RX_CRC_EN
        check("crc_val", RX_CRC, 8'hF4);
`else
        check("crc_val", RX_CRC, 8'h00);
`endif
        check("crc_last_wr", wr_log[wr_log.size()-1], 8'h39);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
